// File: rtl/seq_shift_unit_pkg.sv
// Shared definitions for the multi-cycle shift unit: operation modes and FSM state encodings.
package seq_shift_unit_pkg;

  typedef enum logic [1:0] {
    MODE_LSL = 2'b00,
    MODE_LSR = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROL = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/seq_shift_unit_step.sv
// Single-bit shift step: produces the next accumulator value and the bit that leaves the MSB.
module shift_step
  import seq_shift_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] acc,
  input  mode_e            mode,
  output logic [WIDTH-1:0] acc_next,
  output logic             shout
);

  // one-position shift selected by the latched mode
  always_comb begin
    acc_next = acc;
    shout    = acc[WIDTH-1];
    case (mode)
      MODE_LSL: acc_next = {acc[WIDTH-2:0], 1'b0};
      MODE_LSR: acc_next = {1'b0, acc[WIDTH-1:1]};
      MODE_ASR: acc_next = {acc[WIDTH-1], acc[WIDTH-1:1]};
      MODE_ROL: acc_next = {acc[WIDTH-2:0], acc[WIDTH-1]};
      default:  acc_next = acc;
    endcase
  end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift unit: one bit position per clock under a start/ready/done handshake.
module seq_shift_unit
  import seq_shift_unit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic             overflow
);

  localparam logic [SHW-1:0] CNT_ONE = SHW'(1'b1);
  localparam logic [SHW-1:0] CNT_MAX = SHW'(WIDTH-1);

  state_e           state_r, state_nxt_s;
  logic [SHW-1:0]   cnt_r;
  logic [SHW-1:0]   shamt_sat_s;
  logic [WIDTH-1:0] acc_r;
  mode_e            mode_r;
  logic             ovf_r;
  logic [WIDTH-1:0] step_acc_s;
  logic             step_out_s;
  logic [WIDTH-1:0] res_s;
  logic             res_ovf_s;
  logic             ready_r, busy_r, done_r, overflow_r;
  logic [WIDTH-1:0] dout_r;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_r),
    .mode     (mode_r),
    .acc_next (step_acc_s),
    .shout    (step_out_s)
  );

  assign shamt_sat_s = (32'(shamt) > 32'(WIDTH-1)) ? CNT_MAX : shamt;

  // next-state decode and the result that is published when entering DONE
  always_comb begin
    state_nxt_s = state_r;
    res_s       = din;
    res_ovf_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = (shamt_sat_s != '0) ? ST_SHIFT : ST_DONE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        res_s     = step_acc_s;
        res_ovf_s = (mode_r == MODE_LSL) && (ovf_r || step_out_s);
        if (cnt_r == CNT_ONE) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_DONE:  state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // state register and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == ST_IDLE);
      busy_r  <= (state_nxt_s == ST_SHIFT);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  // operand capture and per-cycle shifting; inputs are ignored outside an IDLE accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r  <= '0;
      cnt_r  <= '0;
      mode_r <= MODE_LSL;
      ovf_r  <= 1'b0;
    end else if ((state_r == ST_IDLE) && start) begin
      acc_r  <= din;
      cnt_r  <= shamt_sat_s;
      mode_r <= mode_e'(mode);
      ovf_r  <= 1'b0;
    end else if (state_r == ST_SHIFT) begin
      acc_r  <= step_acc_s;
      cnt_r  <= cnt_r - CNT_ONE;
      ovf_r  <= ovf_r | ((mode_r == MODE_LSL) & step_out_s);
    end
  end

  // result registers load on entry to DONE so they are valid during the done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_r     <= '0;
      overflow_r <= 1'b0;
    end else if ((state_nxt_s == ST_DONE) && (state_r != ST_DONE)) begin
      dout_r     <= res_s;
      overflow_r <= res_ovf_s;
    end
  end

  assign ready    = ready_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign dout     = dout_r;
  assign overflow = overflow_r;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit (WIDTH=8, SHW=3) against an arithmetic reference model.
module tb_seq_shift_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] mode;
  logic [2:0] shamt;
  logic [7:0] din;
  logic       ready, busy, done, overflow;
  logic [7:0] dout;

  int ncomp = 0;
  int nfail = 0;

  seq_shift_unit #(.WIDTH(8), .SHW(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .shamt(shamt), .din(din),
    .ready(ready), .busy(busy), .done(done), .dout(dout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected result from multiply/divide/rotate arithmetic on plain integers
  function automatic void ref_model(input logic [7:0] d, input logic [1:0] m, input int n,
                                    output logic [7:0] r, output logic o);
    int v, sv;
    v = int'(d);
    o = 1'b0;
    case (m)
      2'd0: begin r = 8'((v * (1 << n)) % 256); o = ((v * (1 << n)) / 256) != 0; end
      2'd1: r = 8'(v / (1 << n));
      2'd2: begin sv = (v >= 128) ? v - 256 : v; r = 8'(sv >>> n); end
      default: r = 8'(((v << n) | (v >> (8 - n))) % 256);
    endcase
  endfunction

  // Drive one operation from a negedge; returns at the negedge after the done pulse.
  task automatic run_op(input logic [7:0] d, input logic [1:0] m, input logic [2:0] s, input bit intf);
    int n, c;
    logic [7:0] er;
    logic eo;
    bit seen_busy;
    n = int'(s);
    ref_model(d, m, n, er, eo);
    start = 1'b1; din = d; mode = m; shamt = s;
    @(posedge clk);
    @(negedge clk);
    din = 8'($urandom); mode = 2'($urandom); shamt = 3'($urandom);
    c = 0;
    seen_busy = 1'b0;
    while (c < 20) begin
      start = (intf && c == 1);
      if (start) din = ~d;
      if (done) break;
      if (busy) seen_busy = 1'b1;
      c++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("latency", c, n);
    chk("busy_seen", 32'(seen_busy), 32'(n > 0));
    chk("dout", 32'(dout), 32'(er));
    chk("overflow", 32'(overflow), 32'(eo));
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("ready_after", 32'(ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mode = 2'd0; shamt = 3'd0; din = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8'h0C, 2'd0, 3'd3, 1'b0);
    run_op(8'hF0, 2'd0, 3'd2, 1'b0);
    run_op(8'h90, 2'd1, 3'd2, 1'b0);
    run_op(8'h90, 2'd2, 3'd2, 1'b0);
    run_op(8'h81, 2'd3, 3'd1, 1'b0);
    for (int k = 0; k < 4; k++) run_op(8'h5A, 2'(k), 3'd0, 1'b0);
    run_op(8'hB3, 2'd2, 3'd5, 1'b1);
    run_op(8'h81, 2'd0, 3'd7, 1'b0);

    // reset in the second SHIFT cycle aborts the operation
    start = 1'b1; din = 8'hC3; mode = 2'd3; shamt = 3'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_dout", 32'(dout), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
    end
    run_op(8'h0C, 2'd0, 3'd3, 1'b0);

    for (int k = 0; k < 40; k++) begin
      run_op(8'($urandom), 2'($urandom), 3'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
